picorv32_pcpi_gfmul: RTL and testbench

PICORV32_PCPI_GFMUL -- requirements
Module: picorv32_pcpi_gfmul

---
 rtl/picorv32_gf_pkg.sv | 46 ++++
 rtl/gf8_mac_step.sv | 22 ++
 rtl/picorv32_pcpi_gfmul.sv | 108 ++++++++++
 tb/tb_picorv32_pcpi_gfmul.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_gf_pkg.sv
// Shared definitions for the PCPI carry-less / GF(2^8) multiply coprocessor.
//   - instruction field codes (opcode, funct7, funct3)
//   - FSM state encoding
//   - operand request record latched on acceptance
//   - decode helper used to decide whether an instruction is claimed
package picorv32_gf_pkg;

  localparam logic [6:0] GF_OPCODE = 7'b0001011;  // custom-0
  localparam logic [6:0] GF_FUNCT7 = 7'b0000100;

  localparam logic [2:0] F3_CLMUL  = 3'b000;
  localparam logic [2:0] F3_CLMULH = 3'b001;
  localparam logic [2:0] F3_GF8MUL = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // Counter preload values: the counter runs down to zero, so load iters-1.
  localparam logic [4:0] CLMUL_LAST_CNT = 5'd31;
  localparam logic [4:0] GF8_LAST_CNT   = 5'd7;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;  // shifted left one bit per BUSY cycle
  } gf_req_t;

  function automatic logic gf_decode(input logic [31:0] insn, input logic en_clmulh);
    logic hit;
    hit = 1'b0;
    if (insn[6:0] == GF_OPCODE && insn[31:25] == GF_FUNCT7) begin
      case (insn[14:12])
        F3_CLMUL:  hit = 1'b1;
        F3_CLMULH: hit = en_clmulh;
        F3_GF8MUL: hit = 1'b1;
        default:   hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/gf8_mac_step.sv
// One MSB-first GF(2^8) multiply-accumulate step for a single byte lane.
//   acc   : running product
//   a     : multiplicand byte
//   b_bit : current multiplier bit (MSB first)
//   nxt   : xtime(acc) ^ (b_bit ? a : 0)
// Purely combinational; the reduction polynomial's low byte is GF8_POLY.
module gf8_mac_step #(
  parameter logic [7:0] GF8_POLY = 8'h1B
) (
  input  logic [7:0] acc,
  input  logic [7:0] a,
  input  logic       b_bit,
  output logic [7:0] nxt
);

  logic [7:0] xt;

  // Doubling with reduction: the bit shifted out of x^7 folds back via the poly.
  assign xt  = {acc[6:0], 1'b0} ^ (acc[7] ? GF8_POLY : 8'h00);
  assign nxt = xt ^ (b_bit ? a : 8'h00);

endmodule

// File: rtl/picorv32_pcpi_gfmul.sv
// PCPI coprocessor: CLMUL / CLMULH (32x32 carry-less multiply, low/high word)
// and GF8MUL (four independent GF(2^8) byte multiplies).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   pcpi_valid/insn     : instruction offer from the core (held until ready)
//   pcpi_rs1/rs2        : operands, latched on acceptance
//   pcpi_wait           : high while an accepted instruction is in flight
//   pcpi_ready/wr/rd    : one-cycle completion pulse with result
// Bit-serial: one multiplier bit per BUSY cycle, 32 cycles for CLMUL(H),
// 8 for GF8MUL, then a single DONE cycle carrying the result.
module picorv32_pcpi_gfmul
  import picorv32_gf_pkg::*;
#(
  parameter int         ENABLE_CLMULH = 1,
  parameter logic [7:0] GF8_POLY      = 8'h1B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  logic [1:0]  state;
  gf_req_t     req;
  logic [63:0] acc;
  logic [4:0]  cnt;

  logic        claim;
  logic        is_gf;
  logic        last;
  logic [63:0] clmul_nxt;
  logic [63:0] acc_nxt;
  logic [31:0] result;
  logic [NUM_LANES-1:0][LANE_W-1:0] gf_nxt;

  assign claim = pcpi_valid && gf_decode(pcpi_insn, ENABLE_CLMULH != 0);
  assign is_gf = (req.funct3 == F3_GF8MUL);
  assign last  = (cnt == 5'd0);

  assign clmul_nxt = {acc[62:0], 1'b0} ^ (req.rs2[31] ? {32'h0, req.rs1} : 64'h0);

  // GF lanes share the whole-word multiplier shift: after j shifts, bit 8i+7
  // still holds lane i's original bit (7-j), so no per-lane shifting is needed.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gf8_mac_step #(.GF8_POLY(GF8_POLY)) u_step (
      .acc   (acc[i*LANE_W +: LANE_W]),
      .a     (req.rs1[i*LANE_W +: LANE_W]),
      .b_bit (req.rs2[i*LANE_W + LANE_W-1]),
      .nxt   (gf_nxt[i])
    );
  end

  assign acc_nxt = is_gf ? {32'h0, gf_nxt} : clmul_nxt;

  always_comb begin
    result = acc_nxt[31:0];
    if (req.funct3 == F3_CLMULH) result = acc_nxt[63:32];
  end

  assign pcpi_wait = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      req        <= '0;
      acc        <= '0;
      cnt        <= '0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
    end else begin
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      case (state)
        ST_IDLE: begin
          if (claim) begin
            state <= ST_BUSY;
            req   <= '{funct3: pcpi_insn[14:12], rs1: pcpi_rs1, rs2: pcpi_rs2};
            acc   <= '0;
            cnt   <= (pcpi_insn[14:12] == F3_GF8MUL) ? GF8_LAST_CNT : CLMUL_LAST_CNT;
          end
        end
        ST_BUSY: begin
          // Runs to completion even if the core withdraws pcpi_valid.
          acc     <= acc_nxt;
          req.rs2 <= {req.rs2[30:0], 1'b0};
          cnt     <= cnt - 5'd1;
          if (last) begin
            state      <= ST_DONE;
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            pcpi_rd    <= result;
          end
        end
        ST_DONE: state <= ST_IDLE;  // never re-accepts here
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_pcpi_gfmul.sv
// Directed bench for picorv32_pcpi_gfmul. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_picorv32_pcpi_gfmul;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  int checks = 0;
  int errors = 0;

  picorv32_pcpi_gfmul #(.ENABLE_CLMULH(1), .GF8_POLY(8'h1B)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
  endfunction

  localparam logic [6:0] F7_GF  = 7'b0000100;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  // Offers one instruction and observes it to completion (no comparisons here).
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rd, output logic wr,
                        output logic wait_ok, output logic quiet_ok, output logic ready_after);
    @(negedge clk);
    pcpi_insn = ins; pcpi_rs1 = a; pcpi_rs2 = b; pcpi_valid = 1'b1;
    @(posedge clk);  // accept edge
    lat = 0; rd = '0; wr = 1'b0; wait_ok = 1'b1; quiet_ok = 1'b1;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (!pcpi_wait) wait_ok = 1'b0;
      if (pcpi_ready) begin
        lat = n; rd = pcpi_rd; wr = pcpi_wr;
      end else if (pcpi_rd !== 32'h0 || pcpi_wr !== 1'b0) begin
        quiet_ok = 1'b0;
      end
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
    ready_after = pcpi_ready;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({pcpi_wait, pcpi_ready, pcpi_wr} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: wait/ready/wr=%b expected 000", {pcpi_wait, pcpi_ready, pcpi_wr});
    end
    checks++;
    if (pcpi_rd !== 32'h0) begin
      errors++; $display("FAIL reset_rd: got %h expected 00000000", pcpi_rd);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (pcpi_wait !== 1'b0) begin
      errors++; $display("FAIL reset_idle_wait: got %b expected 0", pcpi_wait);
    end
  endtask

  task automatic test_clmul();
    int lat; logic [31:0] rd; logic wr, wok, qok, rafter;
    run_op(mk_insn(F7_GF, 3'b000), 32'h3, 32'h3, lat, rd, wr, wok, qok, rafter);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL clmul_3x3_rd: got %h expected 00000005", rd); end
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL clmul_wr: got %b expected 1", wr); end
    checks++; if (lat != 33) begin errors++; $display("FAIL clmul_latency: got %0d expected 33", lat); end
    checks++; if (wok !== 1'b1) begin errors++; $display("FAIL clmul_wait_held: wait dropped before ready"); end
    checks++; if (qok !== 1'b1) begin errors++; $display("FAIL clmul_rd_quiet: rd/wr nonzero without ready"); end
    checks++; if (rafter !== 1'b0) begin errors++; $display("FAIL clmul_ready_width: ready %b one cycle later, expected 0", rafter); end
    run_op(mk_insn(F7_GF, 3'b000), 32'h8000_0000, 32'h8000_0000, lat, rd, wr, wok, qok, rafter);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clmul_msb_rd: got %h expected 00000000", rd); end
  endtask

  task automatic test_clmulh();
    int lat; logic [31:0] rd; logic wr, wok, qok, rafter;
    run_op(mk_insn(F7_GF, 3'b001), 32'h8000_0000, 32'h8000_0000, lat, rd, wr, wok, qok, rafter);
    checks++; if (rd !== 32'h4000_0000) begin errors++; $display("FAIL clmulh_msb_rd: got %h expected 40000000", rd); end
    checks++; if (lat != 33) begin errors++; $display("FAIL clmulh_latency: got %0d expected 33", lat); end
    // all-ones squared: bit k set iff the pair count is odd -> 0x55555555 both halves
    run_op(mk_insn(F7_GF, 3'b001), 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rd, wr, wok, qok, rafter);
    checks++; if (rd !== 32'h5555_5555) begin errors++; $display("FAIL clmulh_ones_rd: got %h expected 55555555", rd); end
  endtask

  task automatic test_gf8mul();
    int lat; logic [31:0] rd; logic wr, wok, qok, rafter;
    run_op(mk_insn(F7_GF, 3'b010), 32'h5757_5757, 32'h8383_8383, lat, rd, wr, wok, qok, rafter);
    checks++; if (rd !== 32'hC1C1_C1C1) begin errors++; $display("FAIL gf8_rd: got %h expected C1C1C1C1", rd); end
    checks++; if (lat != 9) begin errors++; $display("FAIL gf8_latency: got %0d expected 9", lat); end
    checks++; if (wok !== 1'b1) begin errors++; $display("FAIL gf8_wait_held: wait dropped before ready"); end
    // lanes: 57*83=C1, 02*87=15, 01*FF=FF, 00*FF=00
    run_op(mk_insn(F7_GF, 3'b010), 32'h5702_0100, 32'h8387_FFFF, lat, rd, wr, wok, qok, rafter);
    checks++; if (rd !== 32'hC115_FF00) begin errors++; $display("FAIL gf8_lanes_rd: got %h expected C115FF00", rd); end
  endtask

  task automatic test_unclaimed();
    logic [31:0] ins [2];
    ins[0] = mk_insn(F7_MUL, 3'b000);
    ins[1] = mk_insn(F7_GF, 3'b011);
    for (int k = 0; k < 2; k++) begin
      int bad;
      bad = 0;
      @(negedge clk);
      pcpi_insn = ins[k]; pcpi_rs1 = 32'h3; pcpi_rs2 = 32'h3; pcpi_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (pcpi_wait || pcpi_ready || pcpi_wr) bad++;
      end
      pcpi_valid = 1'b0;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL unclaimed_%0d: %0d active cycles expected 0", k, bad); end
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic [31:0] rd; logic wr, wok, qok, rafter;
    @(negedge clk);
    pcpi_insn = mk_insn(F7_GF, 3'b000); pcpi_rs1 = 32'h1234_5678; pcpi_rs2 = 32'hFFFF_FFFF; pcpi_valid = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (pcpi_wait !== 1'b1) begin errors++; $display("FAIL midop_busy: wait=%b expected 1", pcpi_wait); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({pcpi_wait, pcpi_ready, pcpi_wr} !== 3'b000 || pcpi_rd !== 32'h0) begin
      errors++; $display("FAIL midop_reset_outputs: wait/ready/wr=%b rd=%h expected 000/00000000",
                         {pcpi_wait, pcpi_ready, pcpi_wr}, pcpi_rd);
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op(mk_insn(F7_GF, 3'b010), 32'h0202_0202, 32'h8787_8787, lat, rd, wr, wok, qok, rafter);
    checks++; if (rd !== 32'h1515_1515) begin errors++; $display("FAIL midop_after_rd: got %h expected 15151515", rd); end
    checks++; if (lat != 9) begin errors++; $display("FAIL midop_after_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_back_to_back();
    int first, lat2, pulses;
    logic [31:0] rd1, rd2;
    logic idle_busy;
    first = 0; lat2 = 0; pulses = 0; rd1 = '0; rd2 = '0; idle_busy = 1'b1;
    @(negedge clk);
    pcpi_insn = mk_insn(F7_GF, 3'b000); pcpi_rs1 = 32'h3; pcpi_rs2 = 32'h3; pcpi_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60 && first == 0; n++) begin
      @(negedge clk);
      if (pcpi_ready) begin first = n; rd1 = pcpi_rd; end
    end
    // In DONE: next instruction offered immediately, valid kept high.
    pcpi_insn = mk_insn(F7_GF, 3'b010); pcpi_rs1 = 32'h5757_5757; pcpi_rs2 = 32'h8383_8383;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) idle_busy = pcpi_wait | pcpi_ready;
      if (pcpi_ready) begin
        pulses++;
        if (lat2 == 0) begin lat2 = n; rd2 = pcpi_rd; pcpi_valid = 1'b0; end
      end
    end
    checks++; if (first != 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", first); end
    checks++; if (rd1 !== 32'h5) begin errors++; $display("FAIL b2b_first_rd: got %h expected 00000005", rd1); end
    checks++; if (idle_busy !== 1'b0) begin errors++; $display("FAIL b2b_no_done_accept: wait|ready=%b expected 0", idle_busy); end
    checks++; if (lat2 != 10) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 10", lat2); end
    checks++; if (rd2 !== 32'hC1C1_C1C1) begin errors++; $display("FAIL b2b_second_rd: got %h expected C1C1C1C1", rd2); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_abort();
    int lat, pulses;
    logic [31:0] rd;
    lat = 0; pulses = 0; rd = '0;
    @(negedge clk);
    pcpi_insn = mk_insn(F7_GF, 3'b010); pcpi_rs1 = 32'h0202_0202; pcpi_rs2 = 32'h8787_8787; pcpi_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 3) pcpi_valid = 1'b0;
      if (pcpi_ready) begin
        pulses++;
        if (lat == 0) begin lat = n; rd = pcpi_rd; end
      end
    end
    checks++; if (lat != 9) begin errors++; $display("FAIL abort_latency: got %0d expected 9", lat); end
    checks++; if (rd !== 32'h1515_1515) begin errors++; $display("FAIL abort_rd: got %h expected 15151515", rd); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL abort_pulses: got %0d expected 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_clmul();
    test_clmulh();
    test_gf8mul();
    test_unclaimed();
    test_reset_midop();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
